mopshub_can_rec_arbiter: RTL and testbench
==========================================

Name: mopshub_can_rec_arbiter

Overview:
Receive-side arbiter between the 16 CAN bus controllers and the e-link uplink packer of mopshub_top_16bus. It scans per-bus receive interrupts round-robin and drives can_rec_select to the winning bus. It reads one 76-bit frame per grant through a req/ack handshake and forwards it as data_rec_uplink with a valid/ready handshake. A watchdog drops reads from buses that never acknowledge, so one dead MOPS bus cannot stall the uplink.

Parameters:
N_BUS, 16, number of CAN bus interrupt inputs (max 32)
DATA_W, 76, CAN frame word width
TIMEOUT_CYC, 255, cycles allowed between rd_req and rd_ack before a read is abandoned

Ports:
clk  in  1  system clock (40 MHz domain)
rst  in  1  asynchronous, active-low reset
n_buses  in  5  index of highest enabled bus; values above N_BUS-1 saturate to N_BUS-1
irq_can_rec  in  N_BUS  level per bus: frame pending, held until read
rd_req  out  1  one-cycle pulse: read frame from bus can_rec_select
rd_ack  in  1  frame_in valid this cycle
frame_in  in  DATA_W  frame from the selected CAN controller
can_rec_select  out  5  currently granted bus index
data_rec_uplink  out  DATA_W  frame to uplink packer
uplink_valid  out  1  data_rec_uplink valid
uplink_ready  in  1  uplink packer can accept
irq_elink_rec  out  1  one-cycle pulse on each completed uplink transfer
err_timeout  out  1  one-cycle pulse when a read is abandoned
timeout_cnt  out  8  saturating count of abandoned reads

Behaviour:
- Reset (rst=0, async): state IDLE, can_rec_select=0, rr pointer=0, rd_req=0, uplink_valid=0, data_rec_uplink=0, irq_elink_rec=0, err_timeout=0, timeout_cnt=0, watchdog=0.
- Mask: bus i is eligible when irq_can_rec[i]=1 and i<=n_buses_sat. n_buses is sampled every cycle.
- States: IDLE, READ, PUSH.
- IDLE: if any bus is eligible, pick the first eligible index scanning from the pointer upward, wrapping after n_buses_sat to 0. Register it into can_rec_select, pulse rd_req for one cycle, clear the watchdog, and go to READ. If no bus is eligible, stay in IDLE; can_rec_select holds its last value.
- Latency from irq to rd_req is 1 cycle: an eligible irq at edge t gives rd_req high for cycle t+1.
- READ: the watchdog increments each cycle.
  - rd_ack=1: latch frame_in into data_rec_uplink, set uplink_valid=1, go to PUSH.
  - Watchdog reaches TIMEOUT_CYC without rd_ack: pulse err_timeout, increment timeout_cnt (saturate at 255), advance the pointer, go to IDLE.
  - rd_ack and timeout in the same cycle: the ack wins.
- PUSH: data_rec_uplink and uplink_valid are held stable until uplink_ready=1. The transfer happens on the cycle where valid&ready are both 1. Next cycle: uplink_valid=0, irq_elink_rec pulses, pointer = granted+1 (wrap to 0 if > n_buses_sat), go to IDLE.
  - uplink_ready may already be high on entry, giving 1-cycle residence in PUSH.
- Minimum frame period per grant is 4 cycles (IDLE, READ with immediate ack, PUSH, IDLE).
- rd_ack outside READ is ignored and causes no state change.
- An irq dropping during READ does not cancel the read; only ack or timeout ends it.
- If n_buses shrinks below the granted bus mid-transaction, the transaction completes and the pointer then wraps to 0.
- Fairness: any continuously asserted eligible bus is served within n_buses_sat+1 grants.
- Reset asserted mid-operation aborts immediately. A held frame is discarded and no irq_elink_rec is issued.

Decomposition:
- Shared package mopshub_pkg holds:
  - constants CAN_FRAME_W=76, MAX_BUS=32
  - typedef arb_state_t {IDLE, READ, PUSH}
  - typedef bus_id_t (logic [4:0])
- One sub-module, rr_priority_pick: combinational round-robin first-one finder.
  - Inputs: request vector, pointer, n_buses_sat.
  - Outputs: grant index and any_req.
  - Reused later by the transmit-side bus selector.

Test Plan:
- Single request: irq_can_rec=16'h0010, n_buses=15, rd_ack 2 cycles after rd_req with frame 76'hA5… → can_rec_select=4, one rd_req, data_rec_uplink=frame, irq_elink_rec one pulse, pointer=5.
- Round-robin: irq_can_rec=16'hFFFF held, immediate ack, ready=1 → grants 0,1,…,15,0 in order, each 4 cycles apart.
- Masking: irq_can_rec=16'h8001, n_buses=3 → only bus 0 served repeatedly; bus 15 is never selected; n_buses=31 saturates so bus 15 is served.
- Timeout: irq on bus 7, rd_ack never asserted → err_timeout at rd_req+255 cycles, timeout_cnt=1, next grant moves to bus 8 if pending.
- Back-pressure: uplink_ready=0 for 20 cycles after ack → uplink_valid and data held constant for 20 cycles, no new rd_req, transfer on the first ready cycle.
- Reset mid-PUSH: rst=0 while uplink_valid=1 → all outputs go to reset values asynchronously, no irq_elink_rec, and the pointer is 0 after release.

Source files
------------

// File: rtl/mopshub_pkg.sv
// rtl/mopshub_pkg.sv - shared types and constants for the mopshub CAN arbiters
package mopshub_pkg;

  localparam int CAN_FRAME_W = 76;
  localparam int MAX_BUS     = 32;

  typedef logic [4:0] bus_id_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t READ = 2'd1;
  localparam arb_state_t PUSH = 2'd2;

  // Clamp the highest enabled bus index to what the instance actually has.
  function automatic bus_id_t sat_bus(input bus_id_t n, input int n_bus);
    if (int'(n) > n_bus - 1) begin
      return bus_id_t'(n_bus - 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/mopshub_can_rec_arbiter_if.sv
// rtl/mopshub_can_rec_arbiter_if.sv - CAN read handshake and uplink stream of the receive arbiter
interface mopshub_can_rec_arbiter_if
  import mopshub_pkg::*;
#(
  parameter int DATA_W = CAN_FRAME_W
) ();

  logic              rd_req;
  logic              rd_ack;
  logic [DATA_W-1:0] frame_in;
  bus_id_t           can_rec_select;
  logic [DATA_W-1:0] data_rec_uplink;
  logic              uplink_valid;
  logic              uplink_ready;

  modport master (
    output rd_req,
    output can_rec_select,
    output data_rec_uplink,
    output uplink_valid,
    input  rd_ack,
    input  frame_in,
    input  uplink_ready
  );

  modport slave (
    input  rd_req,
    input  can_rec_select,
    input  data_rec_uplink,
    input  uplink_valid,
    output rd_ack,
    output frame_in,
    output uplink_ready
  );

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin first-one finder over enabled buses
module rr_priority_pick
  import mopshub_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] req,
  input  bus_id_t      ptr,
  input  bus_id_t      n_sat,
  output bus_id_t      grant,
  output logic         any_req
);

  logic [N-1:0] elig;
  logic [N-1:0] upper;
  bus_id_t      first_elig;
  bus_id_t      first_upper;

  always_comb begin
    elig  = '0;
    upper = '0;
    for (int i = 0; i < N; i++) begin
      elig[i]  = req[i] && (i <= int'(n_sat));
      upper[i] = elig[i] && (i >= int'(ptr));
    end
  end

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    first_elig  = '0;
    first_upper = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        first_elig = bus_id_t'(i);
      end
      if (upper[i]) begin
        first_upper = bus_id_t'(i);
      end
    end
  end

  // A pointer past n_sat leaves upper empty, which wraps the scan to bus 0.
  assign any_req = |elig;
  assign grant   = (|upper) ? first_upper : first_elig;

endmodule

// File: rtl/mopshub_can_rec_arbiter.sv
// rtl/mopshub_can_rec_arbiter.sv - round-robin receive arbiter from CAN buses to the e-link uplink
module mopshub_can_rec_arbiter
  import mopshub_pkg::*;
#(
  parameter int N_BUS       = 16,
  parameter int DATA_W      = CAN_FRAME_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4:0]                    n_buses,
  input  logic [N_BUS-1:0]              irq_can_rec,
  mopshub_can_rec_arbiter_if.master     bus,
  output logic                          irq_elink_rec,
  output logic                          err_timeout,
  output logic [7:0]                    timeout_cnt
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  arb_state_t        state;
  bus_id_t           sel_q;
  bus_id_t           ptr_q;
  logic [WD_W-1:0]   wd;
  logic              rd_req_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  bus_id_t n_sat;
  bus_id_t grant;
  logic    any_req;
  bus_id_t next_ptr;

  assign n_sat = sat_bus(n_buses, N_BUS);

  rr_priority_pick #(
    .N (N_BUS)
  ) u_pick (
    .req     (irq_can_rec),
    .ptr     (ptr_q),
    .n_sat   (n_sat),
    .grant   (grant),
    .any_req (any_req)
  );

  // Uses the live n_sat so a bus count shrunk mid-transaction wraps to 0.
  assign next_ptr = (sel_q >= n_sat) ? '0 : sel_q + 5'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      sel_q         <= '0;
      ptr_q         <= '0;
      wd            <= '0;
      rd_req_q      <= 1'b0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      irq_elink_rec <= 1'b0;
      err_timeout   <= 1'b0;
      timeout_cnt   <= '0;
    end else begin
      rd_req_q      <= 1'b0;
      irq_elink_rec <= 1'b0;
      err_timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel_q    <= grant;
            rd_req_q <= 1'b1;
            wd       <= '0;
            state    <= READ;
          end
        end
        READ: begin
          wd <= wd + 1'b1;
          // Ack is checked first so a same-cycle ack beats the watchdog.
          if (bus.rd_ack) begin
            data_q  <= bus.frame_in;
            valid_q <= 1'b1;
            state   <= PUSH;
          end else if (wd == WD_LAST) begin
            err_timeout <= 1'b1;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            ptr_q <= next_ptr;
            state <= IDLE;
          end
        end
        PUSH: begin
          if (bus.uplink_ready) begin
            valid_q       <= 1'b0;
            irq_elink_rec <= 1'b1;
            ptr_q         <= next_ptr;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_req          = rd_req_q;
  assign bus.can_rec_select  = sel_q;
  assign bus.uplink_valid    = valid_q;
  assign bus.data_rec_uplink = data_q;

endmodule

// File: tb/tb_mopshub_can_rec_arbiter.sv
// tb/tb_mopshub_can_rec_arbiter.sv - self-checking bench for mopshub_can_rec_arbiter
module tb_mopshub_can_rec_arbiter;

  localparam logic [75:0] JUNK = 76'h0F0F0F0F0F0F0F0F0F0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  n_buses = 5'd15;
  logic [15:0] irq_can_rec = '0;
  logic        irq_elink_rec;
  logic        err_timeout;
  logic [7:0]  timeout_cnt;

  mopshub_can_rec_arbiter_if #(.DATA_W(76)) bif ();

  mopshub_can_rec_arbiter #(
    .N_BUS       (16),
    .DATA_W      (76),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .n_buses       (n_buses),
    .irq_can_rec   (irq_can_rec),
    .bus           (bif),
    .irq_elink_rec (irq_elink_rec),
    .err_timeout   (err_timeout),
    .timeout_cnt   (timeout_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [75:0] mk_frame(input logic [4:0] b);
    return {16'hA5A5, 11'h0, b, 39'h5AC3C33C3C, b};
  endfunction

  // CAN controller model: acks ack_lat cycles after seeing rd_req (0 = never).
  int   ack_lat   = 2;
  int   pend      = 0;
  logic ack_force = 1'b0;
  logic ack_m;

  initial begin
    bif.rd_ack   = 1'b0;
    bif.frame_in = JUNK;
    forever begin
      @(posedge clk);
      #1;
      ack_m = 1'b0;
      if (!rst) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) ack_m = 1'b1;
        end
        if (bif.rd_req && ack_lat > 0) pend = ack_lat;
      end
      bif.rd_ack   = ack_m | ack_force;
      bif.frame_in = ack_m ? mk_frame(bif.can_rec_select) : JUNK;
    end
  end

  // Scoreboard of expected granted bus ids, popped on each uplink transfer.
  logic [4:0] exp_q[$];
  int n_req = 0, n_xfer = 0, n_elink = 0, n_to = 0;
  bit rr_chk = 1'b0;
  int prev_req_cyc = -1;

  always @(negedge clk) begin
    if (rst) begin
      if (bif.rd_req) begin
        n_req++;
        if (rr_chk) begin
          if (prev_req_cyc >= 0) chk("rr_period", cyc - prev_req_cyc, 4);
          prev_req_cyc = cyc;
        end
      end
      if (bif.uplink_valid && bif.uplink_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          chk("xfer_sel", bif.can_rec_select, e);
          chk("xfer_data", bif.data_rec_uplink, mk_frame(e));
        end
      end
      if (irq_elink_rec) n_elink++;
      if (err_timeout) n_to++;
    end
  end

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bif.rd_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bif.uplink_valid && !bif.rd_req) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bif.uplink_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct packed {
    logic [15:0] irq;
    logic [4:0]  nb;
    logic        grant;
    logic [4:0]  sel;
  } vec_t;

  vec_t tbl [15];

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench stopped");
  end

  initial begin
    bit ok;
    int r0, e0, x0, t0, t_req;

    tbl[0]  = '{16'h0010, 5'd15, 1'b1, 5'd4};
    tbl[1]  = '{16'h0021, 5'd15, 1'b1, 5'd5};
    tbl[2]  = '{16'h0021, 5'd15, 1'b1, 5'd0};
    tbl[3]  = '{16'h8001, 5'd3,  1'b1, 5'd0};
    tbl[4]  = '{16'h8001, 5'd3,  1'b1, 5'd0};
    tbl[5]  = '{16'h8000, 5'd3,  1'b0, 5'd0};
    tbl[6]  = '{16'h8001, 5'd31, 1'b1, 5'd15};
    tbl[7]  = '{16'h8001, 5'd31, 1'b1, 5'd0};
    tbl[8]  = '{16'h0003, 5'd0,  1'b1, 5'd0};
    tbl[9]  = '{16'h0003, 5'd0,  1'b1, 5'd0};
    tbl[10] = '{16'h0003, 5'd1,  1'b1, 5'd0};
    tbl[11] = '{16'h0003, 5'd1,  1'b1, 5'd1};
    tbl[12] = '{16'hC000, 5'd15, 1'b1, 5'd14};
    tbl[13] = '{16'hC000, 5'd15, 1'b1, 5'd15};
    tbl[14] = '{16'h0000, 5'd15, 1'b0, 5'd0};

    bif.uplink_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_req", bif.rd_req, 0);
    chk("rst_valid", bif.uplink_valid, 0);
    chk("rst_sel", bif.can_rec_select, 0);
    chk("rst_data", bif.data_rec_uplink, 0);
    chk("rst_elink", irq_elink_rec, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_tcnt", timeout_cnt, 0);
    rst = 1'b1;
    @(negedge clk);

    // Table: single grants with ack two cycles after rd_req.
    ack_lat = 2;
    for (int v = 0; v < 15; v++) begin
      n_buses = tbl[v].nb;
      r0 = n_req;
      e0 = n_elink;
      if (tbl[v].grant) begin
        exp_q.push_back(tbl[v].sel);
        irq_can_rec = tbl[v].irq;
        wait_req(20, ok);
        chk("vec_req_seen", ok, 1);
        chk("vec_sel", bif.can_rec_select, tbl[v].sel);
        irq_can_rec = '0;
        wait_idle(20, ok);
        chk("vec_done", ok, 1);
        chk("vec_req_cnt", n_req - r0, 1);
        chk("vec_elink_cnt", n_elink - e0, 1);
      end else begin
        irq_can_rec = tbl[v].irq;
        repeat (10) @(negedge clk);
        chk("vec_no_grant", n_req - r0, 0);
        irq_can_rec = '0;
      end
    end

    // Round-robin over all 16 buses with immediate ack.
    ack_lat = 1;
    n_buses = 5'd15;
    for (int i = 0; i < 17; i++) exp_q.push_back(5'(i % 16));
    r0 = n_req;
    x0 = n_xfer;
    prev_req_cyc = -1;
    rr_chk = 1'b1;
    irq_can_rec = 16'hFFFF;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_req - r0 >= 17) break;
    end
    irq_can_rec = '0;
    rr_chk = 1'b0;
    wait_idle(20, ok);
    chk("rr_done", ok, 1);
    chk("rr_xfers", n_xfer - x0, 17);

    // Timeout on bus 7, then the next grant moves on to bus 8.
    ack_lat = 0;
    irq_can_rec = 16'h0180;
    wait_req(20, ok);
    chk("to_req_seen", ok, 1);
    chk("to_sel", bif.can_rec_select, 7);
    t_req = cyc;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        ok = 1'b1;
        break;
      end
    end
    chk("to_seen", ok, 1);
    chk("to_delay", cyc - t_req, 255);
    chk("to_cnt", timeout_cnt, 1);
    ack_lat = 1;
    exp_q.push_back(5'd8);
    wait_req(20, ok);
    chk("to_next_sel", bif.can_rec_select, 8);
    irq_can_rec = '0;
    wait_idle(20, ok);
    chk("to_next_done", ok, 1);

    // Ack on the same cycle the watchdog expires: the ack wins.
    ack_lat = 254;
    t0 = n_to;
    exp_q.push_back(5'd10);
    irq_can_rec = 16'h0400;
    wait_req(20, ok);
    chk("race_sel", bif.can_rec_select, 10);
    irq_can_rec = '0;
    wait_idle(300, ok);
    chk("race_done", ok, 1);
    chk("race_no_timeout", n_to - t0, 0);
    chk("race_tcnt", timeout_cnt, 1);

    // rd_ack while idle is ignored.
    r0 = n_req;
    e0 = n_elink;
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    ack_force = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ack_valid", bif.uplink_valid, 0);
    chk("idle_ack_req", n_req - r0, 0);
    chk("idle_ack_elink", n_elink - e0, 0);

    // Back-pressure: hold for 20 cycles while bus 1 is also pending.
    ack_lat = 1;
    bif.uplink_ready = 1'b0;
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd1);
    irq_can_rec = 16'h0003;
    wait_req(20, ok);
    chk("bp_sel", bif.can_rec_select, 0);
    irq_can_rec = 16'h0002;
    wait_valid(10, ok);
    chk("bp_valid_seen", ok, 1);
    r0 = n_req;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", bif.uplink_valid, 1);
      chk("bp_hold_data", bif.data_rec_uplink, mk_frame(5'd0));
    end
    chk("bp_no_req", n_req - r0, 0);
    @(posedge clk);
    #1 bif.uplink_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_elink", irq_elink_rec, 1);
    wait_req(20, ok);
    chk("bp_next_sel", bif.can_rec_select, 1);
    irq_can_rec = '0;
    wait_idle(20, ok);
    chk("bp_done", ok, 1);

    // Reset while a frame is held in PUSH.
    bif.uplink_ready = 1'b0;
    exp_q.push_back(5'd2);
    irq_can_rec = 16'h0004;
    wait_req(20, ok);
    chk("rp_sel", bif.can_rec_select, 2);
    irq_can_rec = '0;
    wait_valid(10, ok);
    chk("rp_valid_seen", ok, 1);
    e0 = n_elink;
    rst = 1'b0;
    #1;
    chk("rp_valid", bif.uplink_valid, 0);
    chk("rp_data", bif.data_rec_uplink, 0);
    chk("rp_sel0", bif.can_rec_select, 0);
    chk("rp_tcnt", timeout_cnt, 0);
    chk("rp_elink", irq_elink_rec, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    bif.uplink_ready = 1'b1;
    rst = 1'b1;
    exp_q.push_back(5'd0);
    irq_can_rec = 16'h0009;
    wait_req(20, ok);
    chk("rp_ptr_sel", bif.can_rec_select, 0);
    irq_can_rec = '0;
    wait_idle(20, ok);
    chk("rp_done", ok, 1);
    chk("rp_elink_cnt", n_elink - e0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
